counter8_tc: RTL and testbench



---
 rtl/counter_pkg.sv | 11 +
 rtl/counter8_tc_tc_decode.sv | 18 +
 rtl/counter8_tc.sv | 37 +++
 tb/tb_counter8_tc.sv | 120 ++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and types for the loadable terminal-count counter.
// Holds the default width, the count type and the all-ones terminal value.
package counter_pkg;

  localparam int DEF_WIDTH = 8;

  typedef logic [DEF_WIDTH-1:0] count_t;

  localparam count_t TC_DEFAULT = '1;

endpackage

// File: rtl/counter8_tc_tc_decode.sv
// Terminal-count decode: flags when the count equals TC_VALUE.
// Kept separate so a registered or early-terminal variant can replace it.
module tc_decode
  import counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] TC_VALUE = {WIDTH{1'b1}}
) (
  input  logic [WIDTH-1:0] count,
  output logic             tcount
);

  // Pure equality compare on the registered count
  always_comb begin
    tcount = (count == TC_VALUE);
  end

endmodule

// File: rtl/counter8_tc.sv
// Loadable binary up-counter with a terminal-count strobe.
// Priority per edge: reset, then load, then increment with wrap.
module counter8_tc
  import counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] TC_VALUE = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] preset,
  output logic             tcount
);

  logic [WIDTH-1:0] count;

  // Count register: reset beats load beats increment
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= preset;
    end else begin
      count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  tc_decode #(
    .WIDTH    (WIDTH),
    .TC_VALUE (TC_VALUE)
  ) u_decode (
    .count  (count),
    .tcount (tcount)
  );

endmodule

// File: tb/tb_counter8_tc.sv
// Scoreboard bench for counter8_tc: driver queues expected state,
// monitor pops and compares after every rising edge.
module tb_counter8_tc;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic [7:0] preset = 8'h00;
  logic       tcount;

  typedef struct packed {
    logic [7:0] cnt;
    logic       tc;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   nstep = 0;

  counter8_tc dut (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .preset (preset),
    .tcount (tcount)
  );

  always #5 clk = ~clk;

  // Monitor: every edge with a queued expectation is checked
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (tcount !== e.tc) begin
        bad++;
        $display("FAIL tcount step %0d: got %0b want %0b",
                 e.id, tcount, e.tc);
      end
      total++;
      if (dut.count !== e.cnt) begin
        bad++;
        $display("FAIL count step %0d: got %02h want %02h",
                 e.id, dut.count, e.cnt);
      end
    end
  end

  // Drive one cycle of inputs and queue the hand-computed result
  task automatic step(input logic r, input logic l,
                      input logic [7:0] p,
                      input logic [7:0] ec, input logic et);
    exp_t e;
    @(negedge clk);
    reset  = r;
    load   = l;
    preset = p;
    e.cnt = ec;
    e.tc  = et;
    e.id  = nstep;
    nstep++;
    exp_q.push_back(e);
  endtask

  initial begin
    // reset, then ten counts
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    for (int i = 1; i <= 10; i++)
      step(1'b0, 1'b0, 8'h00, 8'(i), 1'b0);
    // free run up to FF, then wrap
    for (int i = 11; i <= 255; i++)
      step(1'b0, 1'b0, 8'h00, 8'(i), i == 255);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    // second lap: tcount once more at FF
    for (int i = 1; i <= 255; i++)
      step(1'b0, 1'b0, 8'h00, 8'(i), i == 255);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    // load FF held: tcount stays high
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1);
    // load 0A held: no counting
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 8'h0A, 8'h0A, 1'b0);
    // preset ignored while load low
    step(1'b0, 1'b0, 8'h33, 8'h0B, 1'b0);
    step(1'b0, 1'b0, 8'h77, 8'h0C, 1'b0);
    // load FE then release
    step(1'b0, 1'b1, 8'hFE, 8'hFE, 1'b0);
    step(1'b0, 1'b0, 8'h00, 8'hFF, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    // reset beats load
    step(1'b1, 1'b1, 8'hFF, 8'h00, 1'b0);
    // reach 40 then load 10
    step(1'b0, 1'b1, 8'h3F, 8'h3F, 1'b0);
    step(1'b0, 1'b0, 8'h00, 8'h40, 1'b0);
    step(1'b0, 1'b1, 8'h10, 8'h10, 1'b0);
    step(1'b0, 1'b0, 8'h00, 8'h11, 1'b0);
    // reset mid count
    step(1'b1, 1'b0, 8'h55, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h55, 8'h01, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    load  = 1'b0;
    // drain with a bounded wait
    for (int i = 0; i < 5 && exp_q.size() > 0; i++)
      @(negedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
